// File: rtl/or_accum.sv
`default_nettype none
// ============================================================================
//  Module      : or_accum
//  Description : Frame-based bitwise reduction. Folds up to FRAME_LEN samples
//                with OR into one result and presents it through a
//                valid/ready handshake. A flush closes a non-empty frame
//                early. Defining OR_ACCUM_AND_EN adds a per-frame 'mode'
//                input: mode=1 selects AND reduction for that frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module or_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
`ifdef OR_ACCUM_AND_EN
    input  logic             mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic [7:0]       out_count
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [7:0] C_FRAME_LEN = 8'(FRAME_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_live;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       w_cnt_inc;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic [7:0]       r_out_count;
    logic [7:0]       w_out_count_nxt;
    logic             w_accept;
    logic             w_and_sel;
    logic [WIDTH-1:0] w_fold;

    // r_live holds in_ready low until the first edge after reset release
    assign in_ready  = (r_state == ST_ACC) && r_live && !rst;
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_any   = |r_out_data;

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + 8'd1;

`ifdef OR_ACCUM_AND_EN
    logic r_mode;

    // The first sample of a frame takes mode straight from the port;
    // later samples use the copy latched with that first sample.
    assign w_and_sel = (r_cnt == 8'd0) ? mode : r_mode;

    // Latch the reduction mode alongside the first sample of each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
        end else if (w_accept && (r_cnt == 8'd0)) begin
            r_mode <= mode;
        end
    end
`else
    assign w_and_sel = 1'b0;
`endif

    assign w_fold = w_and_sel ? (r_acc & in_data) : (r_acc | in_data);

    // Next-state, accumulator and result-capture logic
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_count_nxt = r_out_count;
        case (r_state)
            ST_ACC: begin
                if (w_accept) begin
                    w_acc_nxt = (r_cnt == 8'd0) ? in_data : w_fold;
                    w_cnt_nxt = w_cnt_inc;
                end
                // Close on a full frame, or on flush when the frame is
                // non-empty (counting a sample accepted this same edge).
                if ((w_accept && (w_cnt_inc == C_FRAME_LEN)) ||
                    (flush && ((r_cnt != 8'd0) || w_accept))) begin
                    w_out_data_nxt  = w_acc_nxt;
                    w_out_count_nxt = w_cnt_nxt;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_live      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= 8'd0;
            r_out_data  <= '0;
            r_out_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_count <= w_out_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/or_accum.md
OR_ACCUM -- requirements
Module: or_accum

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of each input sample and of the result; legal range 1..32.
REQ-002 Parameter FRAME_LEN, default 4, sets the number of samples reduced per frame; legal range 1..255.
REQ-003 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous, active-high.
REQ-005 Port in_valid  input  1  means a sample is offered on in_data.
REQ-006 Port in_data  input  WIDTH  carries the sample.
REQ-007 Port in_ready  output  1  means the block accepts a sample this cycle.
REQ-008 Port flush  input  1  is a single-cycle request to close the current frame early.
REQ-009 Port out_valid  output  1  means a result is presented.
REQ-010 Port out_ready  input  1  means the consumer takes the result this cycle.
REQ-011 Port out_data  output  WIDTH  is the bitwise reduction of the frame.
REQ-012 Port out_any  output  1  is the OR of all bits of out_data.
REQ-013 Port out_count  output  8  is the number of samples folded into out_data.

Function
REQ-014 Two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 A sample is accepted on any rising edge where in_valid=1 and in_ready=1.
REQ-016 The first accepted sample of a frame loads acc; each later sample updates acc to acc OR in_data; the sample counter increments on every accepted sample.
REQ-017 Frame close condition:
- the FRAME_LEN-th sample is accepted; or
- flush=1 while in ACC with at least one sample already counted or being accepted that cycle.
REQ-018 On frame close the block SHALL:
- register out_data = acc including any sample accepted that same edge;
- register out_count = the sample count including that sample;
- move to HOLD, so out_valid rises exactly one cycle after the closing edge.
REQ-019 flush together with an accepted sample SHALL include that sample in the closed frame.
REQ-020 flush with zero samples counted and no sample accepted SHALL be ignored.
REQ-021 flush asserted in HOLD SHALL be ignored.
REQ-022 In HOLD, out_data, out_count and out_any SHALL stay stable until out_valid=1 and out_ready=1.
REQ-023 That output handshake SHALL return the block to ACC with acc and the counter cleared; in_ready rises the following cycle (no bypass).
REQ-024 With FRAME_LEN=1, every accepted sample SHALL produce one result.
REQ-025 The counter SHALL never exceed FRAME_LEN and SHALL never wrap.
REQ-026 out_any SHALL be combinationally derived from registered out_data.

Reset
REQ-027 While rst=1, the block SHALL hold these values: state=ACC, acc=0, counter=0, out_valid=0, out_data=0, out_count=0, out_any=0.
REQ-028 rst=1 with rst low is impossible; rst=1 SHALL force in_ready=0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result, with no output on exit.
REQ-030 in_ready SHALL become 1 on the first clock edge after rst deasserts.

Configuration
REQ-031 Macro OR_ACCUM_AND_EN, when defined, adds port mode (input, 1 bit).
- mode is latched with the first sample of each frame.
- mode=1 selects bitwise AND reduction for that frame (first sample loads acc, later samples AND in).
- mode=0 selects OR reduction.
- mode changes mid-frame SHALL have no effect.
REQ-032 Without OR_ACCUM_AND_EN, the mode port SHALL be absent and the reduction SHALL always be OR.

Verification
REQ-033 WIDTH=8, FRAME_LEN=4, samples 0x01,0x02,0x04,0x80 back-to-back, out_ready=1 -> out_data=0x87, out_count=4, out_any=1, out_valid one cycle after the 4th sample.
REQ-034 Two samples 0x10,0x20, then flush alone -> out_data=0x30, out_count=2; a second flush with an empty frame -> no output.
REQ-035 Frame closes with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; after the handshake, in_ready=1 the next cycle.
REQ-036 rst pulsed after 3 of 4 samples -> no output; 4 new samples of 0x00 -> out_data=0x00, out_any=0, out_count=4.
REQ-037 OR_ACCUM_AND_EN defined, mode=1, samples 0xFF,0xF0,0x3C,0x30 -> out_data=0x30; same samples with mode=0 -> out_data=0xFF.
REQ-038 FRAME_LEN=1, sample 0x5A accepted together with flush -> one result, out_data=0x5A, out_count=1.
